// File: rtl/usb_input_if.sv
// Byte-in / pixel-word-out bundle between the USB receiver, usb_input and the processing unit.
interface usb_input_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    usb_data_in;
  logic          usb_data_valid;
  logic          usb_sof;
  logic          usb_ready;
  logic [23:0]   data_out;
  logic          data_sof;
  logic          data_valid;
  logic          data_ready;
  logic [LW-1:0] fifo_level;
  logic          sync_err;

  modport master (
    output usb_data_in, usb_data_valid, usb_sof, data_ready,
    input  usb_ready, data_out, data_sof, data_valid, fifo_level, sync_err
  );

  modport slave (
    input  usb_data_in, usb_data_valid, usb_sof, data_ready,
    output usb_ready, data_out, data_sof, data_valid, fifo_level, sync_err
  );
endinterface

// File: rtl/usb_input.sv
// Packs 3 USB bytes into a 24-bit pixel word (sof resyncs packing) and buffers it in a FWFT FIFO.
// Word visible one cycle after its third byte; usb_ready drops only at phase 2 with a full FIFO.
module usb_input #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  usb_input_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  logic [1:0]    phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    mid_q, mid_d;
  logic          sof_hold_q, sof_hold_d;
  logic [24:0]   mem_q [DEPTH];
  logic [24:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          sync_err_q, sync_err_d;

  logic usb_ready;
  logic accept;
  logic push;
  logic pop;

  // Ready looks only at registered state so it never chains through data_ready.
  assign usb_ready = !((phase_q == PH2) && (level_q == LW'(DEPTH)));
  assign accept    = bus.usb_data_valid && usb_ready;
  assign pop       = (level_q != '0) && bus.data_ready;

  always_comb begin
    phase_d    = phase_q;
    hi_d       = hi_q;
    mid_d      = mid_q;
    sof_hold_d = sof_hold_q;
    sync_err_d = sync_err_q;
    push       = 1'b0;

    if (accept) begin
      if (bus.usb_sof && (phase_q != PH0)) begin
        // Frame start mid-word: drop the partial bytes and restart at this byte.
        hi_d       = bus.usb_data_in;
        sof_hold_d = 1'b1;
        phase_d    = PH1;
        sync_err_d = 1'b1;
      end else begin
        case (phase_q)
          PH0: begin
            hi_d       = bus.usb_data_in;
            sof_hold_d = bus.usb_sof;
            phase_d    = PH1;
          end
          PH1: begin
            mid_d   = bus.usb_data_in;
            phase_d = PH2;
          end
          default: begin
            push    = 1'b1;
            phase_d = PH0;
          end
        endcase
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      mem_d[wr_ptr_q] = {sof_hold_q, hi_q, mid_q, bus.usb_data_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH0;
      hi_q       <= '0;
      mid_q      <= '0;
      sof_hold_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sync_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      mid_q      <= mid_d;
      sof_hold_q <= sof_hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sync_err_q <= sync_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.usb_ready  = usb_ready;
  assign bus.data_out   = mem_q[rd_ptr_q][23:0];
  assign bus.data_sof   = mem_q[rd_ptr_q][24];
  assign bus.data_valid = (level_q != '0);
  assign bus.fifo_level = level_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_usb_input.sv
// Scoreboard bench for usb_input: a byte-level model predicts words, a monitor compares every pop.
module tb_usb_input;
  logic clk;
  logic rst_n;

  usb_input_if #(.DEPTH(4)) bus ();

  usb_input #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] exp_q[$];
  logic [1:0]  m_phase;
  logic [7:0]  m_hi, m_mid;
  logic        m_sof;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_hi = 0; m_mid = 0; m_sof = 0; exp_err = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] d, input logic s);
    if (s && m_phase != 0) begin
      m_hi = d; m_sof = 1'b1; m_phase = 1; exp_err = 1'b1;
    end else begin
      case (m_phase)
        2'd0: begin m_hi = d; m_sof = s; m_phase = 1; end
        2'd1: begin m_mid = d; m_phase = 2; end
        default: begin exp_q.push_back({m_sof, m_hi, m_mid, d}); m_phase = 0; end
      endcase
    end
  endtask

  // Entered and left at posedge+1; returns once the byte has transferred.
  task automatic send_byte(input logic [7:0] d, input logic s);
    int  n;
    bit  done;
    bus.usb_data_in    = d;
    bus.usb_sof        = s;
    bus.usb_data_valid = 1'b1;
    done = 0;
    n    = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      done = bus.usb_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.usb_data_valid = 1'b0;
    bus.usb_sof        = 1'b0;
    if (done) model_accept(d, s);
    else check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    bus.data_ready = 1'b1;
    n = 0;
    while (bus.data_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.data_ready = 1'b0;
    check("drain_empty", {31'd0, bus.data_valid}, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  // Pops happen at the next rising edge; compare the head word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.data_valid && bus.data_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", {7'd0, bus.data_sof, bus.data_out}, 32'hFFFF_FFFF);
      else check("word", {7'd0, bus.data_sof, bus.data_out}, {7'd0, exp_q.pop_front()});
    end
  end

  initial begin
    clk = 0;
    rst_n = 0;
    bus.usb_data_in = 0; bus.usb_data_valid = 0; bus.usb_sof = 0; bus.data_ready = 0;
    model_reset();
    #12;
    check("rst_valid", {31'd0, bus.data_valid}, 0);
    check("rst_level", {29'd0, bus.fifo_level}, 0);
    check("rst_err",   {31'd0, bus.sync_err}, 0);
    check("rst_ready", {31'd0, bus.usb_ready}, 1);
    check("rst_dout",  {7'd0, bus.data_sof, bus.data_out}, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Single word and one-cycle latency
    send_byte(8'h12, 1); send_byte(8'h34, 0);
    check("pre_valid", {31'd0, bus.data_valid}, 0);
    send_byte(8'h56, 0);
    check("sw_valid", {31'd0, bus.data_valid}, 1);
    check("sw_dout",  {8'd0, bus.data_out}, 32'h123456);
    check("sw_sof",   {31'd0, bus.data_sof}, 1);
    bus.data_ready = 1;
    @(posedge clk); #1;
    bus.data_ready = 0;
    check("sw_popped", {31'd0, bus.data_valid}, 0);

    // Fill and backpressure
    for (int i = 1; i <= 14; i++) send_byte(8'(i), 0);
    check("fill_level", {29'd0, bus.fifo_level}, 4);
    check("fill_ready", {31'd0, bus.usb_ready}, 0);
    bus.usb_data_in = 8'h0F; bus.usb_data_valid = 1;
    @(posedge clk); #1;
    check("stall_ready", {31'd0, bus.usb_ready}, 0);
    check("stall_level", {29'd0, bus.fifo_level}, 4);
    bus.data_ready = 1;
    @(posedge clk); #1;
    bus.data_ready = 0;
    check("release_ready", {31'd0, bus.usb_ready}, 1);
    check("release_level", {29'd0, bus.fifo_level}, 3);
    send_byte(8'h0F, 0);
    check("refill_level", {29'd0, bus.fifo_level}, 4);
    check("refill_head", {8'd0, bus.data_out}, 32'h040506);
    drain();

    // Resync mid-word
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    send_byte(8'h11, 1); send_byte(8'h22, 0); send_byte(8'h33, 0);
    check("resync_err", {31'd0, bus.sync_err}, {31'd0, exp_err});
    check("resync_level", {29'd0, bus.fifo_level}, 1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", {31'd0, bus.sync_err}, 1);

    // Push and pop in the same cycle at level 2, then wrap over 10 words
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 0);
    bus.data_ready = 1;
    send_byte(8'h48, 0);
    bus.data_ready = 0;
    check("pushpop_level", {29'd0, bus.fifo_level}, 2);
    bus.data_ready = 1;
    for (int i = 0; i < 30; i++) begin
      send_byte(8'($urandom), (m_phase == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    drain();

    // Asynchronous reset between edges
    for (int i = 0; i < 11; i++) send_byte(8'h80 + 8'(i), 0);
    check("pre_rst_level", {29'd0, bus.fifo_level}, 3);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("arst_valid", {31'd0, bus.data_valid}, 0);
    check("arst_level", {29'd0, bus.fifo_level}, 0);
    check("arst_err",   {31'd0, bus.sync_err}, 0);
    check("arst_ready", {31'd0, bus.usb_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    check("post_rst_dout", {8'd0, bus.data_out}, 32'h010203);
    check("post_rst_level", {29'd0, bus.fifo_level}, 1);
    drain();

    // Valid gaps: idle cycles must not advance phase
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hC0 + 8'(i), (i == 0));
      @(posedge clk); #1;
      if (i == 1) check("gap_level", {29'd0, bus.fifo_level}, 0);
    end
    check("gap_words", {29'd0, bus.fifo_level}, 2);
    check("gap_head", {7'd0, bus.data_sof, bus.data_out}, 32'h01C0C1C2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
